// File: rtl/time_bcd_conv_pkg.sv
// Shared definitions for the stopwatch binary-to-BCD display converter.
package time_bcd_conv_pkg;

   localparam int DEF_IN_W    = 6;
   localparam int DEF_MAX_VAL = 59;
   localparam int BCD_W       = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // One double-dabble correction: a nibble of 5 or more would overflow a decimal digit once doubled.
   function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/time_bcd_conv_field.sv
// Shift/add-3 datapath for one time field: holds {tens, ones, binary} and saturates out-of-range values.
module bcd_dabble_field
   import time_bcd_conv_pkg::*;
#(
   parameter int IN_W    = DEF_IN_W,
   parameter int MAX_VAL = DEF_MAX_VAL
) (
   input  logic             incClk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [IN_W-1:0]  bin_i,
   output logic [BCD_W-1:0] tens_o,
   output logic [BCD_W-1:0] ones_o,
   output logic             over_o
);

   localparam int SH_W = 2*BCD_W + IN_W;

   logic [SH_W-1:0] sh_q, sh_d, adj;
   logic            over_q, over_d;

   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
      adj    = sh_q;
      sh_d   = sh_q;
      over_d = over_q;
      adj[IN_W +: BCD_W]         = dabble_adj(sh_q[IN_W +: BCD_W]);
      adj[IN_W+BCD_W +: BCD_W]   = dabble_adj(sh_q[IN_W+BCD_W +: BCD_W]);
      if (load_i) begin
         sh_d   = {{(2*BCD_W){1'b0}}, bin_i};
         over_d = (bin_i > IN_W'(MAX_VAL));
      end else if (shift_i) begin
         sh_d   = {adj[SH_W-2:0], 1'b0};
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge incClk or posedge rst) begin
      if (rst) begin
         sh_q   <= '0;
         over_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         over_q <= over_d;
      end
   end

   assign tens_o = over_q ? 4'd5 : sh_q[IN_W+BCD_W +: BCD_W];
   assign ones_o = over_q ? 4'd9 : sh_q[IN_W +: BCD_W];
   assign over_o = over_q;

endmodule

// File: rtl/time_bcd_conv.sv
// Converts binary minutes/seconds to registered BCD digits with an IDLE/SHIFT/DONE sequencer.
module time_bcd_conv
   import time_bcd_conv_pkg::*;
#(
   parameter int IN_W    = DEF_IN_W,
   parameter int MAX_VAL = DEF_MAX_VAL
) (
   input  logic             incClk,
   input  logic             rst,
   input  logic             start,
   input  logic [IN_W-1:0]  minutes,
   input  logic [IN_W-1:0]  seconds,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [BCD_W-1:0] min_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] sec_ones
);

   localparam int CNT_W = $clog2(IN_W + 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [4*BCD_W-1:0]   dig_q, dig_d;
   logic                 load, shift;
   logic [BCD_W-1:0]     m_tens, m_ones, s_tens, s_ones;
   logic                 m_over, s_over;

   bcd_dabble_field #(.IN_W(IN_W), .MAX_VAL(MAX_VAL)) u_min (
      .incClk (incClk), .rst (rst), .load_i (load), .shift_i (shift), .bin_i (minutes),
      .tens_o (m_tens), .ones_o (m_ones), .over_o (m_over)
   );

   bcd_dabble_field #(.IN_W(IN_W), .MAX_VAL(MAX_VAL)) u_sec (
      .incClk (incClk), .rst (rst), .load_i (load), .shift_i (shift), .bin_i (seconds),
      .tens_o (s_tens), .ones_o (s_ones), .over_o (s_over)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      dig_d   = dig_q;
      load    = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(IN_W - 1)) state_d = DONE;
         end
         DONE: begin
            dig_d   = {m_tens, m_ones, s_tens, s_ones};
            err_d   = m_over | s_over;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge incClk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dig_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dig_q   <= dig_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
   assign {min_tens, min_ones, sec_tens, sec_ones} = dig_q;

endmodule

// File: tb/tb_time_bcd_conv.sv
// Directed self-checking bench for time_bcd_conv with hand-computed digit expectations.
module tb_time_bcd_conv;

   logic       incClk = 1'b0;
   logic       rst;
   logic       start;
   logic [5:0] minutes, seconds;
   logic       busy, done, err;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic [15:0] digs;

   int n_tests = 0;
   int n_fail  = 0;

   time_bcd_conv dut (
      .incClk   (incClk),
      .rst      (rst),
      .start    (start),
      .minutes  (minutes),
      .seconds  (seconds),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .min_tens (min_tens),
      .min_ones (min_ones),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones)
   );

   always #5 incClk = ~incClk;

   assign digs = {min_tens, min_ones, sec_tens, sec_ones};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge incClk);
      #1;
   endtask

   // Present inputs and hold start across exactly one rising edge.
   task automatic start_conv(input logic [5:0] m, input logic [5:0] s);
      minutes = m;
      seconds = s;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Called right after the start edge; expects done seven edges later and busy for seven samples.
   task automatic wait_done(input string tag);
      int n;
      int b;
      n = 0;
      b = busy ? 1 : 0;
      while (!done && n < 20) begin
         tick();
         n++;
         if (busy) b++;
      end
      check({tag, " latency"}, n, 7);
      check({tag, " busy_cycles"}, b, 7);
   endtask

   initial begin
      int pulses;
      rst     = 1'b1;
      start   = 1'b0;
      minutes = '0;
      seconds = '0;
      #12;
      check("reset outputs", {busy, done, err, digs}, '0);
      rst = 1'b0;

      start_conv(6'd0, 6'd0);
      wait_done("zero");
      check("zero digits", digs, 16'h0000);
      check("zero err", err, 0);

      start_conv(6'd59, 6'd59);
      wait_done("max");
      check("max digits", digs, 16'h5959);
      check("max err", err, 0);
      tick();
      check("done single cycle", done, 0);

      start_conv(6'd12, 6'd37);
      minutes = 6'd45;
      seconds = 6'd8;
      wait_done("input change");
      check("input change digits", digs, 16'h1237);

      start_conv(6'd63, 6'd7);
      wait_done("over");
      check("over digits", digs, 16'h5907);
      check("over err", err, 1);
      repeat (4) tick();
      check("hold digits", digs, 16'h5907);
      check("hold err", err, 1);

      start_conv(6'd10, 6'd10);
      wait_done("err clear");
      check("err clear digits", digs, 16'h1010);
      check("err clear err", err, 0);

      // Second start pulse at edge k+3 must be ignored.
      start_conv(6'd20, 6'd30);
      pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3) begin
            minutes = 6'd1;
            seconds = 6'd1;
            start   = 1'b1;
         end
         tick();
         start = 1'b0;
         if (done) pulses++;
      end
      check("ignored start pulses", pulses, 1);
      check("ignored start digits", digs, 16'h2030);

      // Reset during SHIFT aborts the conversion.
      start_conv(6'd45, 6'd33);
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("abort digits", digs, 16'h0000);
      check("abort busy", busy, 0);
      check("abort err", err, 0);
      #3;
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) pulses++;
      end
      check("abort no done", pulses, 0);

      start_conv(6'd1, 6'd2);
      wait_done("after reset");
      check("after reset digits", digs, 16'h0102);
      check("after reset err", err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/time_bcd_conv.md
TIME_BCD_CONV -- requirements
Module: time_bcd_conv

Interface
REQ-001 Parameter IN_W, default 6, width of each binary time field.
REQ-002 Parameter MAX_VAL, default 59, largest legal field value.
REQ-003 incClk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to convert the current minutes/seconds; sampled only in IDLE.
REQ-006 minutes  input  IN_W  binary minutes from the stopwatch counter.
REQ-007 seconds  input  IN_W  binary seconds from the stopwatch counter.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  single-cycle pulse; new digits are valid.
REQ-010 err  output  1  latched range flag for the last completed conversion.
REQ-011 min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD digits for the display stage.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 SHALL capture minutes and seconds into shift registers, clear the shift count, set busy, and go to SHIFT.
REQ-014 IDLE with start=0 SHALL hold all outputs.
REQ-015 In SHIFT, each cycle SHALL perform one double-dabble step on both fields in parallel: add 3 to any BCD nibble >=5, then shift left one bit.
REQ-016 SHIFT SHALL last exactly IN_W cycles, then go to DONE.
REQ-017 DONE SHALL load the four digit outputs and err, pulse done for one cycle, clear busy, and return to IDLE.
REQ-018 Latency: start sampled at edge k SHALL produce done=1 and valid digits after edge k+IN_W+1 (edge k+7 at default).
REQ-019 Minimum start-to-start spacing SHALL be IN_W+2 cycles.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored, with no queueing.
REQ-021 Changes on minutes/seconds after capture SHALL NOT affect the conversion in progress.
REQ-022 If either captured field exceeds MAX_VAL:
- that field's digits SHALL saturate to 5,9;
- err SHALL be set at DONE.
REQ-023 If both fields are within MAX_VAL, err SHALL be cleared at DONE.
REQ-024 Digit outputs and err SHALL hold their values between DONE states.
REQ-025 A field value of 0 SHALL yield digits 0,0.
REQ-026 A field value of MAX_VAL SHALL yield digits 5,9.

Reset
REQ-027 rst=1 SHALL, asynchronously:
- force state to IDLE;
- clear busy, done and err;
- clear all digit outputs;
- clear shift registers and the shift count.
REQ-028 rst asserted mid-SHIFT SHALL abort the conversion, and no done pulse SHALL follow.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-030 The shared time package SHALL hold:
- the state encoding typedef;
- the MAX_VAL and IN_W defaults;
- the BCD digit width constant.
REQ-031 The per-field shift/add-3 datapath SHALL be a sub-module, bcd_dabble_field, instantiated once per field.
REQ-032 The FSM and shift count SHALL live in time_bcd_conv.

Verification
REQ-033 Reset then start with minutes=0, seconds=0 -> done at edge +7; digits 0,0,0,0; err=0.
REQ-034 Start with minutes=59, seconds=59 -> digits 5,9,5,9; err=0; busy high for exactly 7 cycles.
REQ-035 Start with minutes=12, seconds=37, then change inputs to 45/08 mid-SHIFT -> digits 1,2,3,7.
REQ-036 Start with minutes=63, seconds=7 -> digits 5,9,0,7; err=1; next start with 10/10 -> err=0.
REQ-037 Start again at cycle +3 of a conversion -> ignored; exactly one done pulse.
REQ-038 Assert rst at SHIFT cycle 4 -> digits 0, busy 0, no done pulse; a new start with 1/2 -> digits 0,1,0,2.
